// File: rtl/mrna_iso_sequencer_if.sv
// -----------------------------------------------------------------------------
// mrna_iso_sequencer_if
// Bundles the host handshake and the valve-bank pin group of the mRNA isolation
// sequencer.
//   master : host / test controller side (drives start/abort, observes the rest)
//   slave  : sequencer side (samples start/abort, drives status and valve lines)
// Signals:
//   start, abort             host -> sequencer
//   busy, done, step[3:0]    sequencer status
//   *_ctrl  (13 lines)       valve control, 1 = pressurised/closed, 0 = open
//   *_flush (13 lines)       matching flush lines
// -----------------------------------------------------------------------------
interface mrna_iso_sequencer_if;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic [3:0] step;

   logic collect_ctrl, lysis_in_ctrl, lysis_out_ctrl, push_ctrl;
   logic pump1, pump2, pump3;
   logic sep_ctrl, sieve_ctrl, waste_ctrl, beads_ctrl;
   logic cells_in_ctrl, cells_out_ctrl;

   logic collect_flush, lysis_in_flush, lysis_out_flush, push_flush;
   logic pump1_flush, pump2_flush, pump3_flush;
   logic sep_flush, sieve_flush, waste_flush, beads_flush;
   logic cells_in_flush, cells_out_flush;

   modport master (
      output start, abort,
      input  busy, done, step,
      input  collect_ctrl, lysis_in_ctrl, lysis_out_ctrl, push_ctrl,
      input  pump1, pump2, pump3,
      input  sep_ctrl, sieve_ctrl, waste_ctrl, beads_ctrl,
      input  cells_in_ctrl, cells_out_ctrl,
      input  collect_flush, lysis_in_flush, lysis_out_flush, push_flush,
      input  pump1_flush, pump2_flush, pump3_flush,
      input  sep_flush, sieve_flush, waste_flush, beads_flush,
      input  cells_in_flush, cells_out_flush
   );

   modport slave (
      input  start, abort,
      output busy, done, step,
      output collect_ctrl, lysis_in_ctrl, lysis_out_ctrl, push_ctrl,
      output pump1, pump2, pump3,
      output sep_ctrl, sieve_ctrl, waste_ctrl, beads_ctrl,
      output cells_in_ctrl, cells_out_ctrl,
      output collect_flush, lysis_in_flush, lysis_out_flush, push_flush,
      output pump1_flush, pump2_flush, pump3_flush,
      output sep_flush, sieve_flush, waste_flush, beads_flush,
      output cells_in_flush, cells_out_flush
   );
endinterface

// File: rtl/mrna_iso_sequencer.sv
// -----------------------------------------------------------------------------
// mrna_iso_sequencer
// Protocol sequencer for the mRNA isolation valve bank:
//   idle -> load cells -> load beads -> lysis -> peristaltic mix -> separate
//        -> wash -> collect [-> flush] -> idle (done pulse)
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   mrna_iso_sequencer_if.slave: start/abort in; busy, done, step,
//         13 valve ctrl lines and 13 flush lines out
// All outputs are registered Moore decodes of the next state, so they change
// on the same edge as the state register.
// Optional feature: define FLUSH_EN to add the S_FLUSH state after S_COLL
// (all ctrl open, all flush lines high). Without it the flush lines are tied 0.
// -----------------------------------------------------------------------------
module mrna_iso_sequencer #(
   parameter int CNT_W      = 16,
   parameter int T_CELLS    = 400,
   parameter int T_BEADS    = 400,
   parameter int T_LYSIS    = 800,
   parameter int PUMP_DIV   = 100,
   parameter int MIX_CYCLES = 8,
   parameter int T_SEP      = 400,
   parameter int T_WASH     = 400,
   parameter int T_COLL     = 400,
   parameter int T_FLUSH    = 50
) (
   input  logic               clk,
   input  logic               rst,
   mrna_iso_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_CELLS = 4'd1,
      S_BEADS = 4'd2,
      S_LYSIS = 4'd3,
      S_MIX   = 4'd4,
      S_SEP   = 4'd5,
      S_WASH  = 4'd6,
      S_COLL  = 4'd7,
      S_FLUSH = 4'd8
   } state_t;

   // Counter load value: a duration of T cycles loads T-1; zero/negative act as 1.
   function automatic logic [CNT_W-1:0] ld_val(input int t);
      return (t <= 1) ? '0 : CNT_W'(t - 1);
   endfunction

   localparam logic [CNT_W-1:0] L_CELLS = ld_val(T_CELLS);
   localparam logic [CNT_W-1:0] L_BEADS = ld_val(T_BEADS);
   localparam logic [CNT_W-1:0] L_LYSIS = ld_val(T_LYSIS);
   localparam logic [CNT_W-1:0] L_DIV   = ld_val(PUMP_DIV);
   localparam logic [CNT_W-1:0] L_MIX   = ld_val(MIX_CYCLES);
   localparam logic [CNT_W-1:0] L_SEP   = ld_val(T_SEP);
   localparam logic [CNT_W-1:0] L_WASH  = ld_val(T_WASH);
   localparam logic [CNT_W-1:0] L_COLL  = ld_val(T_COLL);
   localparam logic [CNT_W-1:0] L_FLUSH = ld_val(T_FLUSH);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   // Valve vector bit order (MSB..LSB):
   // collect, lysis_in, lysis_out, push, pump1, pump2, pump3,
   // sep, sieve, waste, beads, cells_in, cells_out
   localparam int B_COLLECT   = 12;
   localparam int B_LYSIS_IN  = 11;
   localparam int B_LYSIS_OUT = 10;
   localparam int B_PUSH      = 9;
   localparam int B_SEP       = 5;
   localparam int B_SIEVE     = 4;
   localparam int B_WASTE     = 3;
   localparam int B_BEADS     = 2;
   localparam int B_CELLS_IN  = 1;
   localparam int B_CELLS_OUT = 0;

   // Six-phase peristaltic pattern {pump1,pump2,pump3}; 0 = open.
   function automatic logic [2:0] pump_pat(input logic [2:0] ph);
      logic [2:0] p;
      case (ph)
         3'd0:    p = 3'b100;
         3'd1:    p = 3'b110;
         3'd2:    p = 3'b010;
         3'd3:    p = 3'b011;
         3'd4:    p = 3'b001;
         3'd5:    p = 3'b101;
         default: p = 3'b111;
      endcase
      return p;
   endfunction

   function automatic logic [12:0] ctrl_of(input state_t s, input logic [2:0] ph);
      logic [12:0] c;
      c = '1;
      case (s)
         S_CELLS: begin c[B_CELLS_IN]  = 1'b0; c[B_CELLS_OUT] = 1'b0; end
         S_BEADS: begin c[B_BEADS]     = 1'b0; c[B_CELLS_OUT] = 1'b0; end
         S_LYSIS: begin c[B_LYSIS_IN]  = 1'b0; c[B_LYSIS_OUT] = 1'b0; end
         S_MIX:   begin c[B_SEP]       = 1'b0; c[8:6] = pump_pat(ph);  end
         S_SEP:   begin c[B_SIEVE]     = 1'b0; c[B_WASTE]     = 1'b0; end
         S_WASH:  begin c[B_PUSH]      = 1'b0; c[B_WASTE]     = 1'b0; end
         S_COLL:  begin c[B_PUSH]      = 1'b0; c[B_COLLECT]   = 1'b0; end
         S_FLUSH: c = '0;
         default: c = '1;
      endcase
      return c;
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_phase;
   logic [CNT_W-1:0] r_rot;
   logic [12:0]      r_ctrl;
   logic             r_busy;
   logic             r_done;

   state_t           w_nxt_state;
   logic [CNT_W-1:0] w_nxt_cnt;
   logic [2:0]       w_nxt_phase;
   logic [CNT_W-1:0] w_nxt_rot;
   logic             w_nxt_done;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_phase = r_phase;
      w_nxt_rot   = r_rot;
      w_nxt_done  = 1'b0;
      if (bus.abort) begin
         w_nxt_state = S_IDLE;
         w_nxt_cnt   = '0;
         w_nxt_phase = '0;
         w_nxt_rot   = '0;
      end else begin
         case (r_state)
            S_IDLE:
               if (bus.start) begin
                  w_nxt_state = S_CELLS;
                  w_nxt_cnt   = L_CELLS;
               end
            S_CELLS:
               if (r_cnt == '0) begin
                  w_nxt_state = S_BEADS;
                  w_nxt_cnt   = L_BEADS;
               end else w_nxt_cnt = r_cnt - ONE;
            S_BEADS:
               if (r_cnt == '0) begin
                  w_nxt_state = S_LYSIS;
                  w_nxt_cnt   = L_LYSIS;
               end else w_nxt_cnt = r_cnt - ONE;
            S_LYSIS:
               if (r_cnt == '0) begin
                  w_nxt_state = S_MIX;
                  w_nxt_cnt   = L_DIV;
                  w_nxt_phase = '0;
                  w_nxt_rot   = L_MIX;
               end else w_nxt_cnt = r_cnt - ONE;
            // r_cnt divides phases, r_rot counts remaining full rotations.
            S_MIX:
               if (r_cnt != '0) begin
                  w_nxt_cnt = r_cnt - ONE;
               end else begin
                  w_nxt_cnt = L_DIV;
                  if (r_phase == 3'd5) begin
                     w_nxt_phase = '0;
                     if (r_rot == '0) begin
                        w_nxt_state = S_SEP;
                        w_nxt_cnt   = L_SEP;
                     end else w_nxt_rot = r_rot - ONE;
                  end else w_nxt_phase = r_phase + 3'd1;
               end
            S_SEP:
               if (r_cnt == '0) begin
                  w_nxt_state = S_WASH;
                  w_nxt_cnt   = L_WASH;
               end else w_nxt_cnt = r_cnt - ONE;
            S_WASH:
               if (r_cnt == '0) begin
                  w_nxt_state = S_COLL;
                  w_nxt_cnt   = L_COLL;
               end else w_nxt_cnt = r_cnt - ONE;
            S_COLL:
               if (r_cnt == '0) begin
`ifdef FLUSH_EN
                  w_nxt_state = S_FLUSH;
                  w_nxt_cnt   = L_FLUSH;
`else
                  w_nxt_state = S_IDLE;
                  w_nxt_done  = 1'b1;
`endif
               end else w_nxt_cnt = r_cnt - ONE;
            // Unreachable unless FLUSH_EN routes S_COLL here.
            S_FLUSH:
               if (r_cnt == '0) begin
                  w_nxt_state = S_IDLE;
                  w_nxt_done  = 1'b1;
               end else w_nxt_cnt = r_cnt - ONE;
            default: w_nxt_state = S_IDLE;
         endcase
      end
   end

`ifdef FLUSH_EN
   logic [12:0] r_flush;
`else
   logic [12:0] w_flush;
   assign w_flush = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_phase <= '0;
         r_rot   <= '0;
         r_ctrl  <= '1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef FLUSH_EN
         r_flush <= '0;
`endif
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_phase <= w_nxt_phase;
         r_rot   <= w_nxt_rot;
         r_ctrl  <= ctrl_of(w_nxt_state, w_nxt_phase);
         r_busy  <= (w_nxt_state != S_IDLE);
         r_done  <= w_nxt_done;
`ifdef FLUSH_EN
         r_flush <= (w_nxt_state == S_FLUSH) ? '1 : '0;
`endif
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.step = r_state;

   assign {bus.collect_ctrl, bus.lysis_in_ctrl, bus.lysis_out_ctrl, bus.push_ctrl,
           bus.pump1, bus.pump2, bus.pump3,
           bus.sep_ctrl, bus.sieve_ctrl, bus.waste_ctrl, bus.beads_ctrl,
           bus.cells_in_ctrl, bus.cells_out_ctrl} = r_ctrl;

`ifdef FLUSH_EN
   assign {bus.collect_flush, bus.lysis_in_flush, bus.lysis_out_flush, bus.push_flush,
           bus.pump1_flush, bus.pump2_flush, bus.pump3_flush,
           bus.sep_flush, bus.sieve_flush, bus.waste_flush, bus.beads_flush,
           bus.cells_in_flush, bus.cells_out_flush} = r_flush;
`else
   assign {bus.collect_flush, bus.lysis_in_flush, bus.lysis_out_flush, bus.push_flush,
           bus.pump1_flush, bus.pump2_flush, bus.pump3_flush,
           bus.sep_flush, bus.sieve_flush, bus.waste_flush, bus.beads_flush,
           bus.cells_in_flush, bus.cells_out_flush} = w_flush;
`endif

endmodule

// File: tb/tb_mrna_iso_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mrna_iso_sequencer
// Scoreboard bench for mrna_iso_sequencer with short timings. Each driven start
// pushes the per-cycle expected trace (step, valve map, flush, busy, done) into
// a queue; every cycle one entry is popped and compared one time unit after
// the rising edge. Builds with or without FLUSH_EN.
// -----------------------------------------------------------------------------
module tb_mrna_iso_sequencer;

   typedef struct packed {
      logic [3:0]  step;
      logic [12:0] ctrl;
      logic [12:0] flush;
      logic        busy;
      logic        done;
   } exp_t;

`ifdef FLUSH_EN
   localparam int RUN_LEN = 52;
`else
   localparam int RUN_LEN = 49;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];

   logic [2:0] pump_tbl [6];

   mrna_iso_sequencer_if ifc();

   mrna_iso_sequencer #(
      .CNT_W(16), .T_CELLS(4), .T_BEADS(4), .T_LYSIS(4),
      .PUMP_DIV(2), .MIX_CYCLES(2),
      .T_SEP(4), .T_WASH(4), .T_COLL(4), .T_FLUSH(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   logic [12:0] obs_ctrl;
   logic [12:0] obs_flush;
   assign obs_ctrl  = {ifc.collect_ctrl, ifc.lysis_in_ctrl, ifc.lysis_out_ctrl, ifc.push_ctrl,
                       ifc.pump1, ifc.pump2, ifc.pump3,
                       ifc.sep_ctrl, ifc.sieve_ctrl, ifc.waste_ctrl, ifc.beads_ctrl,
                       ifc.cells_in_ctrl, ifc.cells_out_ctrl};
   assign obs_flush = {ifc.collect_flush, ifc.lysis_in_flush, ifc.lysis_out_flush, ifc.push_flush,
                       ifc.pump1_flush, ifc.pump2_flush, ifc.pump3_flush,
                       ifc.sep_flush, ifc.sieve_flush, ifc.waste_flush, ifc.beads_flush,
                       ifc.cells_in_flush, ifc.cells_out_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   // Expected valve map; bit order collect..cells_out as in obs_ctrl.
   function automatic logic [12:0] exp_ctrl(input int s, input logic [2:0] p);
      logic [12:0] c;
      c = 13'h1FFF;
      case (s)
         1: begin c[1]  = 1'b0; c[0]  = 1'b0; end
         2: begin c[2]  = 1'b0; c[0]  = 1'b0; end
         3: begin c[11] = 1'b0; c[10] = 1'b0; end
         4: begin c[5]  = 1'b0; c[8:6] = p;   end
         5: begin c[4]  = 1'b0; c[3]  = 1'b0; end
         6: begin c[9]  = 1'b0; c[3]  = 1'b0; end
         7: begin c[9]  = 1'b0; c[12] = 1'b0; end
         8: c = 13'h0000;
         default: c = 13'h1FFF;
      endcase
      return c;
   endfunction

   function automatic exp_t mk(input int s, input logic [2:0] p, input logic d);
      exp_t e;
      e.step  = 4'(s);
      e.ctrl  = exp_ctrl(s, p);
      e.flush = (s == 8) ? 13'h1FFF : 13'h0000;
      e.busy  = (s != 0);
      e.done  = d;
      return e;
   endfunction

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 3'b111, 1'b0));
   endtask

   // Full protocol trace starting with the edge that samples start; lim<0 = all.
   task automatic push_run(input int lim);
      exp_t tmp[$];
      for (int s = 1; s <= 3; s++)
         for (int k = 0; k < 4; k++) tmp.push_back(mk(s, 3'b111, 1'b0));
      for (int r = 0; r < 2; r++)
         for (int ph = 0; ph < 6; ph++)
            for (int k = 0; k < 2; k++) tmp.push_back(mk(4, pump_tbl[ph], 1'b0));
      for (int s = 5; s <= 7; s++)
         for (int k = 0; k < 4; k++) tmp.push_back(mk(s, 3'b111, 1'b0));
`ifdef FLUSH_EN
      for (int k = 0; k < 3; k++) tmp.push_back(mk(8, 3'b111, 1'b0));
`endif
      tmp.push_back(mk(0, 3'b111, 1'b1));
      for (int i = 0; i < tmp.size(); i++)
         if (lim < 0 || i < lim) exp_q.push_back(tmp[i]);
   endtask

   task automatic tick(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("step",  32'(ifc.step),  32'(e.step));
            check_val("ctrl",  32'(obs_ctrl),  32'(e.ctrl));
            check_val("flush", 32'(obs_flush), 32'(e.flush));
            check_val("busy",  32'(ifc.busy),  32'(e.busy));
            check_val("done",  32'(ifc.done),  32'(e.done));
         end
      end
   endtask

   task automatic check_idle_now(input string tag);
      check_val({tag, "_step"},  32'(ifc.step),  32'd0);
      check_val({tag, "_ctrl"},  32'(obs_ctrl),  32'h1FFF);
      check_val({tag, "_flush"}, 32'(obs_flush), 32'h0);
      check_val({tag, "_busy"},  32'(ifc.busy),  32'd0);
      check_val({tag, "_done"},  32'(ifc.done),  32'd0);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      pump_tbl[0] = 3'b100; pump_tbl[1] = 3'b110; pump_tbl[2] = 3'b010;
      pump_tbl[3] = 3'b011; pump_tbl[4] = 3'b001; pump_tbl[5] = 3'b101;
      rst       = 1'b1;
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      #3;
      check_idle_now("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Idle after reset
      push_idle(10);
      tick(10);

      // Single start pulse, full protocol, done once
      ifc.start = 1'b1;
      push_run(-1);
      tick(1);
      ifc.start = 1'b0;
      tick(RUN_LEN - 1);
      push_idle(5);
      tick(5);

      // abort beats start in the same cycle
      ifc.start = 1'b1;
      ifc.abort = 1'b1;
      push_idle(1);
      tick(1);
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      push_idle(2);
      tick(2);

      // abort in the second cycle of S_LYSIS, then a full run
      ifc.start = 1'b1;
      push_run(10);
      tick(1);
      ifc.start = 1'b0;
      tick(9);
      ifc.abort = 1'b1;
      push_idle(1);
      tick(1);
      ifc.abort = 1'b0;
      push_idle(4);
      tick(4);
      ifc.start = 1'b1;
      push_run(-1);
      tick(1);
      ifc.start = 1'b0;
      tick(RUN_LEN - 1);
      push_idle(3);
      tick(3);

      // start held high; reset pulsed mid S_SEP; restart after release
      ifc.start = 1'b1;
      push_run(38);
      tick(38);
      #2;
      rst = 1'b1;
      #1;
      check_idle_now("async_rst");
      check_val("q_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      check_idle_now("rst_held");
      rst = 1'b0;
      push_run(-1);
      tick(RUN_LEN);
      ifc.start = 1'b0;
      push_idle(3);
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
